// File: rtl/mxu_result_deskew_if.sv
// Stream bundle for mxu_result_deskew: skewed array results in, aligned vectors out.
// The master drives y/y_valid and out_ready; the deskew block is the slave.
interface mxu_result_deskew_if #(
    parameter int M              = 3,
    parameter int max_data_width = 8
);
    logic                          y_valid;
    logic [M*max_data_width-1:0]   y;
    logic [M*max_data_width-1:0]   out_data;
    logic                          out_valid;
    logic                          out_ready;

    modport master (
        output y_valid,
        output y,
        input  out_data,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  y_valid,
        input  y,
        output out_data,
        output out_valid,
        input  out_ready
    );
endinterface

// File: rtl/mxu_result_deskew.sv
// Removes the per-lane skew of the MXU result vector and buffers aligned vectors in a FIFO.
// Optional feature: define MXU_DESKEW_DROP_CNT_EN to build the saturating drop counter.
module mxu_result_deskew #(
    parameter int M              = 3,
    parameter int max_data_width = 8,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    mxu_result_deskew_if.slave          bus,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    output logic [7:0]                  drop_count,
    output logic                        busy
);
    localparam int DW = max_data_width;
    localparam int VW = M * DW;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [M-2:0]  valid_sr;
    logic [VW-1:0] aligned;
    logic          push_req;
    logic          do_push;
    logic          do_pop;
    logic          fifo_full;
    logic          drop;
    logic [VW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    // Lane i arrives i cycles late, so it is held M-1-i cycles; the last lane is used directly.
    for (genvar i = 0; i < M; i++) begin : g_lane
        if (i == M - 1) begin : g_direct
            assign aligned[i*DW +: DW] = bus.y[i*DW +: DW];
        end else begin : g_delay
            localparam int DEPTH = M - 1 - i;
            logic [DW-1:0] stage [DEPTH];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        stage[k] <= '0;
                    end
                end else begin
                    stage[0] <= bus.y[i*DW +: DW];
                    for (int k = 1; k < DEPTH; k++) begin
                        stage[k] <= stage[k-1];
                    end
                end
            end

            assign aligned[i*DW +: DW] = stage[DEPTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_sr <= '0;
        end else begin
            valid_sr[0] <= bus.y_valid;
            for (int k = 1; k < M - 1; k++) begin
                valid_sr[k] <= valid_sr[k-1];
            end
        end
    end

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign push_req  = valid_sr[M-2];
    assign fifo_full = (count == CW'(FIFO_DEPTH));
    assign do_pop    = bus.out_valid && bus.out_ready;
    assign do_push   = push_req && (!fifo_full || do_pop);
    assign drop      = push_req && fifo_full && !do_pop;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= aligned;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef MXU_DESKEW_DROP_CNT_EN
    logic [7:0] drop_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= 8'd0;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign drop_count = drop_cnt;
`else
    assign drop_count = 8'd0;
`endif

    // Gate the head with out_valid so stale memory never shows up after reset or when drained.
    assign bus.out_valid = (count != '0);
    assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;
    assign fifo_count    = count;
    assign busy          = |valid_sr;

endmodule

// File: tb/tb_mxu_result_deskew.sv
// Directed, table-driven bench for mxu_result_deskew (M=3, 8-bit lanes, 4-entry FIFO).
// Each row gives the aligned vector started that cycle; the bench itself skews it onto y.
module tb_mxu_result_deskew;
    localparam int M          = 3;
    localparam int DW         = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int VW         = M * DW;
`ifdef MXU_DESKEW_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    typedef struct {
        logic          rst;
        logic          yv;
        logic [VW-1:0] vec;
        logic          rdy;
        logic          exp_valid;
        logic [VW-1:0] exp_data;
        logic [2:0]    exp_count;
        logic          exp_ovf;
        logic          exp_busy;
        logic [7:0]    exp_drop;
    } row_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    fifo_count;
    logic          overflow;
    logic [7:0]    drop_count;
    logic          busy;
    int            n_applied = 0;
    int            n_miscompares = 0;
    row_t          rows[$];
    logic [VW-1:0] hist [M];
    logic          hist_v [M];

    mxu_result_deskew_if #(.M(M), .max_data_width(DW)) bus ();

    mxu_result_deskew #(
        .M              (M),
        .max_data_width (DW),
        .FIFO_DEPTH     (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .drop_count (drop_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] mkvec(input int l0, input int l1, input int l2);
        return {8'(l2), 8'(l1), 8'(l0)};
    endfunction

    function automatic void addRow(input logic rst, input logic yv, input logic [VW-1:0] vec,
                                   input logic rdy, input logic ev, input logic [VW-1:0] ed,
                                   input int ec, input logic eo, input logic eb, input int edrop);
        row_t r;
        r.rst       = rst;
        r.yv        = yv;
        r.vec       = vec;
        r.rdy       = rdy;
        r.exp_valid = ev;
        r.exp_data  = ed;
        r.exp_count = 3'(ec);
        r.exp_ovf   = eo;
        r.exp_busy  = eb;
        r.exp_drop  = 8'(edrop);
        rows.push_back(r);
    endfunction

    // Lane k on y comes from the vector started k cycles ago; unowned lanes carry junk.
    task automatic applyStimulus(input logic rst, input logic yv, input logic [VW-1:0] vec,
                                 input logic rdy);
        logic [VW-1:0] ytmp;
        @(negedge clk);
        for (int k = M - 1; k > 0; k--) begin
            hist[k]   = hist[k-1];
            hist_v[k] = hist_v[k-1];
        end
        hist[0]   = vec;
        hist_v[0] = yv;
        ytmp = '0;
        for (int k = 0; k < M; k++) begin
            ytmp[k*DW +: DW] = hist_v[k] ? hist[k][k*DW +: DW] : (8'h5A ^ 8'(k * 17));
        end
        reset         = rst;
        bus.y_valid   = yv;
        bus.y         = ytmp;
        bus.out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int idx, input logic [31:0] act,
                               input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s (row %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.y_valid   = 1'b0;
        bus.y         = '0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < M; k++) begin
            hist[k]   = '0;
            hist_v[k] = 1'b0;
        end

        // Reset held two cycles with random stimulus must leave every output quiet.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            reset         = 1'b1;
            bus.y         = VW'($urandom);
            bus.y_valid   = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            checkOutput("reset_out_valid", -1, 32'(bus.out_valid), 32'd0);
            checkOutput("reset_out_data", -1, 32'(bus.out_data), 32'd0);
            checkOutput("reset_fifo_count", -1, 32'(fifo_count), 32'd0);
            checkOutput("reset_overflow", -1, 32'(overflow), 32'd0);
            checkOutput("reset_drop_count", -1, 32'(drop_count), 32'd0);
            checkOutput("reset_busy", -1, 32'(busy), 32'd0);
        end

        // Single vector 0xFECAFE, visible for exactly one cycle.
        addRow(0, 1, 24'hFECAFE, 1, 0, 24'h0,      0, 0, 1, 0);
        addRow(0, 0, 24'h0,      1, 0, 24'h0,      0, 0, 1, 0);
        addRow(0, 0, 24'h0,      1, 1, 24'hFECAFE, 1, 0, 0, 0);
        addRow(0, 0, 24'h0,      1, 0, 24'h0,      0, 0, 0, 0);

        // Ten back-to-back vectors {n, n+0x10, n+0x20}, drained one per cycle.
        for (int c = 0; c <= 12; c++) begin
            logic ev;
            ev = (c >= 2) && (c <= 11);
            addRow(0, c < 10, mkvec(c + 1, c + 17, c + 33), 1,
                   ev, ev ? mkvec(c - 1, c + 15, c + 31) : 24'h0, ev ? 1 : 0, 0, c <= 10, 0);
        end

        // Six vectors into a stalled FIFO: two drops, then drain the first four.
        addRow(0, 1, mkvec(8'hA1, 8'hB1, 8'hC1), 0, 0, 24'h0,    0, 0, 1, 0);
        addRow(0, 1, mkvec(8'hA2, 8'hB2, 8'hC2), 0, 0, 24'h0,    0, 0, 1, 0);
        addRow(0, 1, mkvec(8'hA3, 8'hB3, 8'hC3), 0, 1, 24'hC1B1A1, 1, 0, 1, 0);
        addRow(0, 1, mkvec(8'hA4, 8'hB4, 8'hC4), 0, 1, 24'hC1B1A1, 2, 0, 1, 0);
        addRow(0, 1, mkvec(8'hA5, 8'hB5, 8'hC5), 0, 1, 24'hC1B1A1, 3, 0, 1, 0);
        addRow(0, 1, mkvec(8'hA6, 8'hB6, 8'hC6), 0, 1, 24'hC1B1A1, 4, 0, 1, 0);
        addRow(0, 0, 24'h0,                      0, 1, 24'hC1B1A1, 4, 1, 1, 1);
        addRow(0, 0, 24'h0,                      0, 1, 24'hC1B1A1, 4, 1, 0, 2);
        addRow(0, 0, 24'h0,                      1, 1, 24'hC2B2A2, 3, 1, 0, 2);
        addRow(0, 0, 24'h0,                      1, 1, 24'hC3B3A3, 2, 1, 0, 2);
        addRow(0, 0, 24'h0,                      1, 1, 24'hC4B4A4, 1, 1, 0, 2);
        addRow(0, 0, 24'h0,                      1, 0, 24'h0,      0, 1, 0, 2);
        addRow(1, 0, 24'h0,                      0, 0, 24'h0,      0, 0, 0, 0);

        // Full FIFO with a push and a pop on the same edge keeps count at 4, no overflow.
        addRow(0, 1, 24'h715141, 0, 0, 24'h0,      0, 0, 1, 0);
        addRow(0, 1, 24'h725242, 0, 0, 24'h0,      0, 0, 1, 0);
        addRow(0, 1, 24'h735343, 0, 1, 24'h715141, 1, 0, 1, 0);
        addRow(0, 1, 24'h745444, 0, 1, 24'h715141, 2, 0, 1, 0);
        addRow(0, 1, 24'h755545, 0, 1, 24'h715141, 3, 0, 1, 0);
        addRow(0, 0, 24'h0,      0, 1, 24'h715141, 4, 0, 1, 0);
        addRow(0, 0, 24'h0,      1, 1, 24'h725242, 4, 0, 0, 0);
        addRow(0, 0, 24'h0,      0, 1, 24'h725242, 4, 0, 0, 0);
        addRow(0, 0, 24'h0,      1, 1, 24'h735343, 3, 0, 0, 0);
        addRow(0, 0, 24'h0,      1, 1, 24'h745444, 2, 0, 0, 0);
        addRow(0, 0, 24'h0,      1, 1, 24'h755545, 1, 0, 0, 0);
        addRow(0, 0, 24'h0,      1, 0, 24'h0,      0, 0, 0, 0);

        // Reset one cycle after lane 0 of 0x998877; the next vector 0x332211 still lands on time.
        addRow(0, 1, 24'h998877, 1, 0, 24'h0,      0, 0, 1, 0);
        addRow(1, 0, 24'h0,      1, 0, 24'h0,      0, 0, 0, 0);
        addRow(0, 1, 24'h332211, 1, 0, 24'h0,      0, 0, 1, 0);
        addRow(0, 0, 24'h0,      1, 0, 24'h0,      0, 0, 1, 0);
        addRow(0, 0, 24'h0,      1, 1, 24'h332211, 1, 0, 0, 0);
        addRow(0, 0, 24'h0,      1, 0, 24'h0,      0, 0, 0, 0);

        foreach (rows[i]) begin
            applyStimulus(rows[i].rst, rows[i].yv, rows[i].vec, rows[i].rdy);
            checkOutput("out_valid", i, 32'(bus.out_valid), 32'(rows[i].exp_valid));
            checkOutput("out_data", i, 32'(bus.out_data), 32'(rows[i].exp_data));
            checkOutput("fifo_count", i, 32'(fifo_count), 32'(rows[i].exp_count));
            checkOutput("overflow", i, 32'(overflow), 32'(rows[i].exp_ovf));
            checkOutput("busy", i, 32'(busy), 32'(rows[i].exp_busy));
            checkOutput("drop_count", i, 32'(drop_count),
                        DROP_EN ? 32'(rows[i].exp_drop) : 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule

// File: doc/mxu_result_deskew.md
# mxu_result_deskew

Output-side realignment stage for the MXU systolic array. The array produces its result vector skewed in time: lane i of a vector arrives i cycles after lane 0. This block removes that skew, re-forms whole result vectors and buffers them in a small FIFO. It then presents them on a valid/ready stream to the output buffer / writeback logic downstream of `mxu_core`.

## Interface
- `M`, 3, number of result lanes (array columns); must be ≥ 2.
- `max_data_width`, 8, bits per lane.
- `FIFO_DEPTH`, 4, aligned-vector FIFO entries; power of 2, ≥ 2.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `y_valid` in 1: lane 0 of a new result vector is present on `y` this cycle.
- `y` in M*max_data_width: skewed array output; lane i = `y[i*max_data_width +: max_data_width]`, lane 0 at the LSBs.
- `out_data` out M*max_data_width: aligned vector at the FIFO head, same lane packing as `y`.
- `out_valid` out 1: FIFO not empty.
- `out_ready` in 1: consumer accepts the head entry this cycle.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: occupied entries.
- `overflow` out 1: sticky; a vector was dropped because the FIFO was full.
- `drop_count` out 8: number of dropped vectors (see Configuration).
- `busy` out 1: at least one partially collected vector is in the skew pipeline.

## Operation
- Skew contract: if `y_valid`=1 at edge E, lane i of that vector is sampled at edge E+i.
- Deskew pipeline:
  - Lane i is delayed by M-1-i register stages.
  - `y_valid` travels along an (M-1)-stage valid shift register.
  - When the valid bit exits the shift register, the concatenated delayed lanes form the aligned vector, and a push is requested.
- Back-to-back `y_valid` (one vector per cycle) is fully supported; vectors overlap in the pipeline.
- FIFO rules:
  - Push when push requested and (not full, or a pop occurs in the same cycle).
  - Pop when `out_valid` && `out_ready`.
  - Push while full with no pop: the vector is dropped, `overflow` is set (sticky until reset) and `drop_count` increments.
  - Pop while empty is ignored.
  - Simultaneous push and pop at any occupancy, including full: both succeed and `fifo_count` is unchanged.
- Read and write pointers wrap modulo FIFO_DEPTH. `fifo_count` ranges from 0 to FIFO_DEPTH.
- `out_data` is valid only while `out_valid`=1. It must remain stable while `out_valid`=1 && `out_ready`=0.
- `busy`=1 while any bit of the valid shift register is set.
- Reset values: `out_valid`=0, `out_data`=0, `fifo_count`=0, `overflow`=0, `drop_count`=0, `busy`=0. All delay lanes and the valid shift register are cleared.
- Reset mid-operation: vectors in the skew pipeline and in the FIFO are discarded; no partial vector is ever emitted.

## Timing
- `y_valid` sampled at edge E → FIFO write at edge E+M-1 → `out_valid`=1 in the cycle after E+M-1, if the FIFO was empty. Latency: M-1 edges.
- Entry popped at edge P: the next entry, or `out_valid`=0, is visible after P.
- `fifo_count`, `overflow` and `drop_count` update on the same edge as the triggering push/pop/drop.
- Sustained throughput: 1 vector/cycle while `out_ready`=1.

## Configuration
- `MXU_DESKEW_DROP_CNT_EN` defined: `drop_count` is an 8-bit counter of dropped vectors. It saturates at 255 and clears on reset.
- `MXU_DESKEW_DROP_CNT_EN` undefined: no counter logic is built and `drop_count` is tied to 0. `overflow` is unaffected.

## Test plan
All scenarios use M=3, max_data_width=8, FIFO_DEPTH=4, with the macro defined.
- Reset: hold `reset`=1 for 2 cycles with random `y` → every output is 0 and `busy`=0.
- Single vector:
  - Stimulus: `y_valid` pulse at E0 with lane0=0xFE; lane1=0xCA at E1; lane2=0xFE at E2; `out_ready`=1.
  - Response: `out_valid` high for exactly one cycle after E2 with `out_data`=0xFECAFE; `fifo_count` returns to 0.
- Streaming: 10 back-to-back skewed vectors with lanes {n, n+0x10, n+0x20} for n=1..10, `out_ready`=1 → 10 outputs in order (0x211101 … 0x2A1A0A), one per cycle, no gaps.
- Backpressure/overflow: `out_ready`=0 while 6 vectors are pushed → `fifo_count`=4, `overflow`=1 at the 5th write edge, `drop_count`=2. After raising `out_ready`, the first 4 vectors drain in order.
- Full with simultaneous push/pop: FIFO full, `out_ready`=1 and a new vector arriving → `fifo_count` stays 4, `overflow` stays 0, order is preserved.
- Reset mid-stream: assert `reset` at E1 of a vector (lane 0 already sampled) → no output for that vector; a following vector completes with normal M-1 latency.
